// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch (IF, read-only)
// and load/store (LS). Each accepted request is registered, held on the memory port for
// MEM_LATENCY cycles, and answered with a one-cycle registered rvalid pulse.
// Optional feature macro: ARB_STARVE_GUARD_EN -- once LS has won STARVE_LIMIT times in a
// row over a waiting IF, the next contested grant goes to IF. Without it LS has strict priority.
//
// state | meaning
// IDLE  | port free; a grant may be issued this cycle
// BUSY  | latched access on the memory port; cnt counts down to the capture cycle
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [1:0]        ls_size,
    input  logic              ls_rdun,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_w_enable,
    output logic [1:0]        mem_access_size,
    output logic              mem_RdUn,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              owner_ls;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wen_q;
    logic [1:0]        size_q;
    logic              rdun_q;
    logic              if_rvalid_q, ls_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    logic grant_if, grant_ls, done, first_busy, starve_force;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);
    logic [STV_W-1:0] starve;

    assign starve_force = (starve == STV_MAX);

    // Count consecutive LS wins while IF waits; any IF grant clears it.
    always_ff @(posedge clk) begin
        if (reset)
            starve <= '0;
        else if (grant_if)
            starve <= '0;
        else if (grant_ls && if_req && !starve_force)
            starve <= starve + 1'b1;
    end
`else
    assign starve_force = 1'b0;
`endif

    // Next-state and grant decision; grants only from IDLE, never during reset.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (ls_req && !(if_req && starve_force))
                        grant_ls = 1'b1;
                    else if (if_req)
                        grant_if = 1'b1;
                    if (grant_ls || grant_if)
                        state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Request latch, latency countdown and response capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            owner_ls    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            size_q      <= '0;
            rdun_q      <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (grant_ls) begin
                owner_ls <= 1'b1;
                addr_q   <= ls_addr;
                wdata_q  <= ls_wdata;
                wen_q    <= ls_wen;
                size_q   <= ls_size;
                rdun_q   <= ls_rdun;
                cnt      <= CNT_INIT;
            end else if (grant_if) begin
                owner_ls <= 1'b0;
                addr_q   <= if_addr;
                wdata_q  <= '0;
                wen_q    <= 1'b0;
                size_q   <= SIZE_WORD;
                rdun_q   <= 1'b0;
                cnt      <= CNT_INIT;
            end else if (state == BUSY && !done) begin
                cnt <= cnt - 1'b1;
            end
            if (done) begin
                if (owner_ls) begin
                    ls_rvalid_q <= 1'b1;
                    ls_rdata_q  <= wen_q ? '0 : mem_data_out;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_data_out;
                end
            end
        end
    end

    // A store writes only on its first BUSY cycle so longer latencies commit once.
    assign first_busy      = (state == BUSY) && (cnt == CNT_INIT);
    assign mem_w_enable    = first_busy && wen_q && !reset;
    assign mem_address     = addr_q;
    assign mem_data_in     = wdata_q;
    assign mem_access_size = size_q;
    assign mem_RdUn        = rdun_q;
    assign if_gnt          = grant_if;
    assign ls_gnt          = grant_ls;
    assign if_rvalid       = if_rvalid_q;
    assign ls_rvalid       = ls_rvalid_q;
    assign if_rdata        = if_rdata_q;
    assign ls_rdata        = ls_rdata_q;
    assign busy            = (state == BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table and sequences plus a randomized run
// against a transaction-level model. A second instance with MEM_LATENCY=3 covers timing.
module tb_mem_port_arbiter;
    localparam int LAT = 1;
    localparam int SLIM = 4;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        if_req, ls_req, ls_wen, ls_rdun;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_w_enable, mem_RdUn, busy;
    logic [31:0] if_rdata, ls_rdata, mem_address, mem_data_in, mem_data_out;
    logic [1:0]  mem_access_size;

    logic        b_if_req, b_ls_req, b_ls_wen, b_ls_rdun;
    logic [31:0] b_if_addr, b_ls_addr, b_ls_wdata;
    logic [1:0]  b_ls_size;
    logic        b_if_gnt, b_if_rvalid, b_ls_gnt, b_ls_rvalid, b_mem_w_enable, b_mem_RdUn, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_mem_address, b_mem_data_in, b_mem_data_out;
    logic [1:0]  b_mem_access_size;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_size(ls_size),
        .ls_rdun(ls_rdun), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_w_enable(mem_w_enable),
        .mem_access_size(mem_access_size), .mem_RdUn(mem_RdUn), .mem_data_out(mem_data_out),
        .busy(busy));

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(SLIM)) dut3 (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .if_rdata(b_if_rdata), .ls_req(b_ls_req), .ls_addr(b_ls_addr), .ls_wen(b_ls_wen),
        .ls_wdata(b_ls_wdata), .ls_size(b_ls_size), .ls_rdun(b_ls_rdun), .ls_gnt(b_ls_gnt),
        .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata), .mem_address(b_mem_address),
        .mem_data_in(b_mem_data_in), .mem_w_enable(b_mem_w_enable),
        .mem_access_size(b_mem_access_size), .mem_RdUn(b_mem_RdUn), .mem_data_out(b_mem_data_out),
        .busy(b_busy));

    // Byte-addressed little-endian memory (environment) and a separate copy for the model.
    logic [7:0] mem_b [1024];
    logic [7:0] ref_b [1024];

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic rdun);
        if (sz == SZ_B) return rdun ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
        if (sz == SZ_H) return rdun ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a, input logic [1:0] sz, input logic rdun);
        logic [9:0] i;
        i = a[9:0];
        return ext({mem_b[i + 10'd3], mem_b[i + 10'd2], mem_b[i + 10'd1], mem_b[i]}, sz, rdun);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a, input logic [1:0] sz, input logic rdun);
        logic [9:0] i;
        i = a[9:0];
        return ext({ref_b[i + 10'd3], ref_b[i + 10'd2], ref_b[i + 10'd1], ref_b[i]}, sz, rdun);
    endfunction

    always_comb mem_data_out   = rd_mem(mem_address, mem_access_size, mem_RdUn);
    always_comb b_mem_data_out = rd_mem(b_mem_address, b_mem_access_size, b_mem_RdUn);

    always @(posedge clk) begin
        if (mem_w_enable) begin
            mem_b[mem_address[9:0]] = mem_data_in[7:0];
            if (mem_access_size != SZ_B) mem_b[mem_address[9:0] + 10'd1] = mem_data_in[15:8];
            if (mem_access_size == SZ_W) begin
                mem_b[mem_address[9:0] + 10'd2] = mem_data_in[23:16];
                mem_b[mem_address[9:0] + 10'd3] = mem_data_in[31:24];
            end
        end
    end

    task automatic ref_wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        ref_b[a[9:0]] = d[7:0];
        if (sz != SZ_B) ref_b[a[9:0] + 10'd1] = d[15:8];
        if (sz == SZ_W) begin
            ref_b[a[9:0] + 10'd2] = d[23:16];
            ref_b[a[9:0] + 10'd3] = d[31:24];
        end
    endtask

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        rdun;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic do_ls(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        ls_req = 1'b1; ls_addr = v.addr; ls_wen = v.wen; ls_wdata = v.wdata;
        ls_size = v.size; ls_rdun = v.rdun;
        #1;
        chk({nm, "_gnt"}, 32'(ls_gnt), 32'd1);
        tick();
        ls_req = 1'b0;
        #1;
        chk({nm, "_wen"}, 32'(mem_w_enable), 32'(v.wen));
        chk({nm, "_addr"}, mem_address, v.addr);
        tick();
        chk({nm, "_rvalid"}, 32'(ls_rvalid), 32'd1);
        chk({nm, "_rdata"}, ls_rdata, v.exp);
        chk({nm, "_wen_after"}, 32'(mem_w_enable), 32'd0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'(i * 7);
        {mem_b[16'h43], mem_b[16'h42], mem_b[16'h41], mem_b[16'h40]} = 32'hDEADBEEF;
        {mem_b[16'h83], mem_b[16'h82], mem_b[16'h81], mem_b[16'h80]} = 32'hCAFEF00D;
        {mem_b[16'h203], mem_b[16'h202], mem_b[16'h201], mem_b[16'h200]} = 32'h11111111;

        vecs[0] = '{1'b1, SZ_W, 1'b0, 32'h100, 32'h12345678, 32'h0};
        vecs[1] = '{1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h12345678};
        vecs[2] = '{1'b1, SZ_B, 1'b0, 32'h101, 32'h000000AB, 32'h0};
        vecs[3] = '{1'b0, SZ_B, 1'b1, 32'h101, 32'h0, 32'h000000AB};
        vecs[4] = '{1'b0, SZ_B, 1'b0, 32'h101, 32'h0, 32'hFFFFFFAB};
        vecs[5] = '{1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h1234AB78};
        vecs[6] = '{1'b1, SZ_H, 1'b0, 32'h102, 32'h00008001, 32'h0};
        vecs[7] = '{1'b0, SZ_H, 1'b0, 32'h102, 32'h0, 32'hFFFF8001};

        reset = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_size = 0; ls_rdun = 0;
        b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_addr = 0; b_ls_wen = 0; b_ls_wdata = 0;
        b_ls_size = 0; b_ls_rdun = 0;

        // Reset held 3 cycles with requests pending: nothing may come out.
        tick();
        for (int c = 0; c < 3; c++) begin
            if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h40; ls_addr = 32'h80;
            #1;
            chk("rst_gnt", {30'h0, if_gnt, ls_gnt}, 32'h0);
            chk("rst_flags", {29'h0, if_rvalid, ls_rvalid, busy}, 32'h0);
            chk("rst_mem", mem_address | mem_data_in | if_rdata | ls_rdata, 32'h0);
            chk("rst_ctl", {28'h0, mem_w_enable, mem_RdUn, mem_access_size}, 32'h0);
            tick();
        end
        reset = 1'b0; if_req = 1'b0; ls_req = 1'b0;

        // Single IF fetch.
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        chk("if1_gnt", {30'h0, if_gnt, ls_gnt}, 32'h2);
        tick();
        if_req = 1'b0;
        #1;
        chk("if1_addr", mem_address, 32'h40);
        chk("if1_busy", 32'(busy), 32'd1);
        chk("if1_early_rvalid", 32'(if_rvalid), 32'd0);
        tick();
        chk("if1_rvalid", 32'(if_rvalid), 32'd1);
        chk("if1_rdata", if_rdata, 32'hDEADBEEF);
        chk("if1_idle", 32'(busy), 32'd0);
        tick();
        chk("if1_pulse_end", 32'(if_rvalid), 32'd0);

        // Simultaneous IF and LS load: LS first, IF granted in LS response cycle.
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_addr = 32'h80; ls_wen = 0; ls_size = SZ_W; ls_rdun = 0;
        #1;
        chk("both_c0", {30'h0, if_gnt, ls_gnt}, 32'h1);
        tick();
        ls_req = 1'b0;
        #1;
        chk("both_c1", {30'h0, if_gnt, ls_gnt}, 32'h0);
        tick();
        chk("both_c2_lsv", {30'h0, if_rvalid, ls_rvalid}, 32'h1);
        chk("both_c2_lsd", ls_rdata, 32'hCAFEF00D);
        chk("both_c2_gnt", {30'h0, if_gnt, ls_gnt}, 32'h2);
        tick();
        if_req = 1'b0;
        tick();
        chk("both_c4_ifv", {30'h0, if_rvalid, ls_rvalid}, 32'h2);
        chk("both_c4_ifd", if_rdata, 32'hDEADBEEF);
        tick();

        // Table of loads and stores of all sizes.
        for (int i = 0; i < 8; i++) do_ls(vecs[i], i);

        // Starvation: both held; IF only wins with the guard, on the 5th opportunity.
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; ls_addr = 32'h80; ls_wen = 0; ls_size = SZ_W; ls_rdun = 0;
        for (int c = 0; c <= 8; c++) begin
            #1;
            chk($sformatf("starve_if_c%0d", c), 32'(if_gnt), 32'(GUARD && c == 8));
            chk($sformatf("starve_ls_c%0d", c), 32'(ls_gnt), 32'((c % 2 == 0) && !(GUARD && c == 8)));
            tick();
        end
        if_req = !GUARD; ls_req = 1'b0;
        tick();
        #1;
        chk("starve_if_after_ls_drop", 32'(if_gnt), 32'(!GUARD));
        tick();
        if_req = 1'b0;
        tick(); tick(); tick();

        // Reset in the middle of a store: nothing written, nothing answered.
        ls_req = 1'b1; ls_addr = 32'h200; ls_wen = 1; ls_wdata = 32'h99999999; ls_size = SZ_W; ls_rdun = 0;
        #1;
        chk("abort_gnt", 32'(ls_gnt), 32'd1);
        tick();
        ls_req = 1'b0; reset = 1'b1;
        #1;
        chk("abort_wen", 32'(mem_w_enable), 32'd0);
        tick();
        reset = 1'b0;
        chk("abort_flags", {30'h0, ls_rvalid, busy}, 32'h0);
        chk("abort_addr", mem_address, 32'h0);
        chk("abort_mem", {mem_b[16'h203], mem_b[16'h202], mem_b[16'h201], mem_b[16'h200]}, 32'h11111111);
        tick();

        // MEM_LATENCY=3 instance: timing of grants, write pulse and responses.
        b_if_req = 1'b1; b_if_addr = 32'h40;
        b_ls_req = 1'b1; b_ls_addr = 32'h80; b_ls_wen = 0; b_ls_size = SZ_W; b_ls_rdun = 0;
        #1;
        chk("l3_c0_gnt", {30'h0, b_if_gnt, b_ls_gnt}, 32'h1);
        tick();
        b_ls_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("l3_c%0d_idle_out", c), {28'h0, b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid}, 32'h0);
            chk($sformatf("l3_c%0d_busy", c), 32'(b_busy), 32'd1);
            tick();
        end
        #1;
        chk("l3_c4_rvalid", 32'(b_ls_rvalid), 32'd1);
        chk("l3_c4_rdata", b_ls_rdata, 32'hCAFEF00D);
        chk("l3_c4_ifgnt", 32'(b_if_gnt), 32'd1);
        tick();
        b_if_req = 1'b0;
        tick(); tick(); tick();
        chk("l3_c8_ifv", 32'(b_if_rvalid), 32'd1);
        chk("l3_c8_ifd", b_if_rdata, 32'hDEADBEEF);
        tick();
        b_ls_req = 1'b1; b_ls_addr = 32'h300; b_ls_wen = 1; b_ls_wdata = 32'h55AA55AA; b_ls_size = SZ_W;
        #1;
        chk("l3s_gnt", 32'(b_ls_gnt), 32'd1);
        tick();
        b_ls_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("l3s_wen_c%0d", c), 32'(b_mem_w_enable), 32'(c == 1));
            chk($sformatf("l3s_wdata_c%0d", c), b_mem_data_in, 32'h55AA55AA);
            tick();
        end
        chk("l3s_ack", 32'(b_ls_rvalid), 32'd1);
        chk("l3s_ack_data", b_ls_rdata, 32'h0);
        tick();

        // Randomized traffic against a transaction-level model.
        begin
            int m_free, exp_cyc, m_starve;
            bit have_exp, exp_ls, g_if, g_ls, idle, ev_if, ev_ls;
            logic [31:0] exp_data;
            int sz;
            for (int i = 0; i < 1024; i++) ref_b[i] = mem_b[i];
            m_free = 0; have_exp = 0; exp_cyc = -1; exp_ls = 0; exp_data = 0; m_starve = 0;
            if_req = 0; ls_req = 0;
            for (int k = 0; k < 3000; k++) begin
                ev_if = have_exp && exp_cyc == k && !exp_ls;
                ev_ls = have_exp && exp_cyc == k && exp_ls;
                chk("rnd_if_rvalid", 32'(if_rvalid), 32'(ev_if));
                chk("rnd_ls_rvalid", 32'(ls_rvalid), 32'(ev_ls));
                if (ev_if) chk("rnd_if_rdata", if_rdata, exp_data);
                if (ev_ls) chk("rnd_ls_rdata", ls_rdata, exp_data);
                chk("rnd_busy", 32'(busy), 32'(k < m_free));
                if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1;
                    if_addr = 32'($urandom_range(0, 255)) << 2;
                end else if (if_req && $urandom_range(0, 15) == 0) begin
                    if_req = 1'b0;
                end
                if (!ls_req && $urandom_range(0, 1) == 0) begin
                    ls_req = 1'b1;
                    sz = $urandom_range(0, 2);
                    ls_size = 2'(sz);
                    ls_addr = 32'($urandom_range(0, 1023)) & ~((32'd1 << sz) - 32'd1);
                    ls_wen = 1'($urandom_range(0, 1));
                    ls_rdun = 1'($urandom_range(0, 1));
                    ls_wdata = $urandom;
                end else if (ls_req && $urandom_range(0, 15) == 0) begin
                    ls_req = 1'b0;
                end
                #1;
                idle = (k >= m_free);
                g_ls = idle && ls_req && !(if_req && GUARD && m_starve == SLIM);
                g_if = idle && if_req && !g_ls;
                chk("rnd_if_gnt", 32'(if_gnt), 32'(g_if));
                chk("rnd_ls_gnt", 32'(ls_gnt), 32'(g_ls));
                if (g_ls || g_if) begin
                    m_free = k + LAT + 1;
                    have_exp = 1; exp_cyc = k + LAT + 1; exp_ls = g_ls;
                    if (g_if) begin
                        exp_data = rd_ref(if_addr, SZ_W, 1'b0);
                        m_starve = 0;
                    end else begin
                        if (if_req && m_starve < SLIM) m_starve++;
                        if (ls_wen) begin
                            ref_wr(ls_addr, ls_size, ls_wdata);
                            exp_data = 0;
                        end else begin
                            exp_data = rd_ref(ls_addr, ls_size, ls_rdun);
                        end
                    end
                end
                tick();
                if (g_ls) ls_req = 1'b0;
                if (g_if) if_req = 1'b0;
            end
            if_req = 0; ls_req = 0;
            tick(); tick(); tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
